// File: rtl/udp_pkg.sv
// Shared constants, state type and header field helpers for the UDP deframer.
package udp_pkg;

   localparam int unsigned UDP_HEADER_BYTES = 8;
   localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;

   // Byte offsets of the big-endian header fields.
   localparam int unsigned HDR_SRC_PORT_OFS = 0;
   localparam int unsigned HDR_DST_PORT_OFS = 2;
   localparam int unsigned HDR_LEN_OFS      = 4;
   localparam int unsigned HDR_CSUM_OFS     = 6;

   typedef enum logic [1:0] {
      HEADER,
      PAYLOAD,
      DISCARD
   } udp_state_t;

   // Header byte k sits at bits [8k+7:8k]; fields are big-endian on the wire.
   function automatic logic [15:0] hdr_u16(input logic [8*UDP_HEADER_BYTES-1:0] hdr,
                                           input int unsigned ofs);
      logic [5:0] lo;
      logic [5:0] hi;
      lo = 6'(8 * ofs);
      hi = 6'(8 * ofs + 8);
      return {hdr[lo +: 8], hdr[hi +: 8]};
   endfunction

endpackage

// File: rtl/udp_deframer_if.sv
// IP payload input stream and UDP payload output stream of the UDP deframer.
interface udp_deframer_if #(
   parameter int unsigned AXIS_BYTES = 4
);
   // Input: IP payload stream with per-packet IP sideband
   logic                    axis_i_tready;
   logic                    axis_i_tvalid;
   logic                    axis_i_tlast;
   logic [8*AXIS_BYTES-1:0] axis_i_tdata;
   logic [AXIS_BYTES-1:0]   axis_i_tkeep;
   logic [15:0]             axis_i_length;
   logic [7:0]              axis_i_protocol;
   logic [31:0]             axis_i_src_ip;
   logic [31:0]             axis_i_dst_ip;

   // Output: UDP payload stream with per-packet UDP sideband
   logic                    axis_o_tready;
   logic                    axis_o_tvalid;
   logic                    axis_o_tlast;
   logic [8*AXIS_BYTES-1:0] axis_o_tdata;
   logic [AXIS_BYTES-1:0]   axis_o_tkeep;
   logic [15:0]             axis_o_length;
   logic [15:0]             axis_o_src_port;
   logic [15:0]             axis_o_dst_port;
   logic [31:0]             axis_o_src_ip;
   logic [31:0]             axis_o_dst_ip;

   // Environment side: drives the IP stream, sinks the UDP stream
   modport master (
      input  axis_i_tready,
      output axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_i_tkeep,
      output axis_i_length, axis_i_protocol, axis_i_src_ip, axis_i_dst_ip,
      output axis_o_tready,
      input  axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tkeep,
      input  axis_o_length, axis_o_src_port, axis_o_dst_port, axis_o_src_ip, axis_o_dst_ip
   );

   // Deframer side
   modport slave (
      output axis_i_tready,
      input  axis_i_tvalid, axis_i_tlast, axis_i_tdata, axis_i_tkeep,
      input  axis_i_length, axis_i_protocol, axis_i_src_ip, axis_i_dst_ip,
      input  axis_o_tready,
      output axis_o_tvalid, axis_o_tlast, axis_o_tdata, axis_o_tkeep,
      output axis_o_length, axis_o_src_port, axis_o_dst_port, axis_o_src_ip, axis_o_dst_ip
   );

endinterface

// File: rtl/axis_pipeline_reg.sv
// One-deep AXI-Stream output register; accepts a new beat whenever the slot is
// empty or being drained in the same cycle, so a stream passes without bubbles.
module axis_pipeline_reg #(
   parameter int unsigned DataBytes = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   input  logic [8*DataBytes-1:0] s_data_i,
   input  logic [DataBytes-1:0]   s_keep_i,
   input  logic                   s_last_i,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [8*DataBytes-1:0] m_data_o,
   output logic [DataBytes-1:0]   m_keep_o,
   output logic                   m_last_o
);

   logic                   valid_q, valid_d;
   logic [8*DataBytes-1:0] data_q, data_d;
   logic [DataBytes-1:0]   keep_q, keep_d;
   logic                   last_q, last_d;

   assign s_ready_o = !valid_q || m_ready_i;
   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;
   assign m_keep_o  = keep_q;
   assign m_last_o  = last_q;

   // Load on input handshake, otherwise empty the slot once the sink takes it
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (s_valid_i && s_ready_o) begin
         valid_d = 1'b1;
         data_d  = s_data_i;
         keep_d  = s_keep_i;
         last_d  = s_last_i;
      end else if (m_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Output slot registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: rtl/udp_deframer.sv
// Strips the UDP header from the IP payload stream and forwards the UDP payload
// with ports, addresses and payload length as per-packet sideband. Non-UDP and
// malformed packets are swallowed and counted.
module udp_deframer
   import udp_pkg::*;
#(
   parameter int unsigned AXIS_BYTES = 4
) (
   input  logic          clk,
   input  logic          sresetn,
   udp_deframer_if.slave bus,
   output logic [31:0]   drop_count
);

   localparam int unsigned DW            = 8 * AXIS_BYTES;
   localparam int unsigned HDR_BITS      = 8 * UDP_HEADER_BYTES;
   localparam int unsigned HDR_BEATS     = UDP_HEADER_BYTES / AXIS_BYTES;
   localparam logic [2:0]  HDR_LAST_BEAT = 3'(HDR_BEATS - 1);
   localparam logic [15:0] HDR_LEN       = 16'(UDP_HEADER_BYTES);
   localparam logic [15:0] BEAT_LEN      = 16'(AXIS_BYTES);

   udp_state_t            state_q, state_d;
   logic                  ready_en_q;
   logic [2:0]            hdr_cnt_q, hdr_cnt_d;
   logic [HDR_BITS-1:0]   hdr_q, hdr_d;
   logic [HDR_BITS-1:0]   hdr_full;
   logic [31:0]           ip_src_q, ip_src_d;
   logic [31:0]           ip_dst_q, ip_dst_d;
   logic [15:0]           rem_q, rem_d;
   logic [31:0]           drop_q, drop_d;
   logic                  drop_inc;

   logic [15:0]           len_q, len_d;
   logic [15:0]           sport_q, sport_d;
   logic [15:0]           dport_q, dport_d;
   logic [31:0]           sip_q, sip_d;
   logic [31:0]           dip_q, dip_d;

   logic                  in_ready;
   logic                  in_fire;
   logic                  hdr_first;
   logic                  hdr_last;
   logic                  hdr_bad;
   logic [15:0]           udp_len;
   logic [31:0]           cur_src_ip;
   logic [31:0]           cur_dst_ip;
   logic [AXIS_BYTES-1:0] rem_keep;

   logic                  pipe_valid;
   logic                  pipe_ready;
   logic [AXIS_BYTES-1:0] pipe_keep;
   logic                  pipe_last;
   logic                  unused_chk;

   // Header bytes arrive lowest-first; the final header beat completes the
   // header combinationally so the accept decision needs no extra cycle.
   if (HDR_BEATS == 1) begin : g_hdr_one_beat
      assign hdr_full = bus.axis_i_tdata;
   end else begin : g_hdr_multi_beat
      assign hdr_full = {bus.axis_i_tdata, hdr_q[HDR_BITS-1 -: HDR_BITS-DW]};
   end

   assign unused_chk = ^{hdr_q, hdr_u16(hdr_full, HDR_CSUM_OFS)};

   assign hdr_first  = (hdr_cnt_q == 3'd0);
   assign hdr_last   = (hdr_cnt_q == HDR_LAST_BEAT);
   assign udp_len    = hdr_u16(hdr_full, HDR_LEN_OFS);
   // IPs are valid on the first beat; that beat may also be the final one
   assign cur_src_ip = hdr_first ? bus.axis_i_src_ip : ip_src_q;
   assign cur_dst_ip = hdr_first ? bus.axis_i_dst_ip : ip_dst_q;
   assign hdr_bad    = (bus.axis_i_protocol != IP_PROTO_UDP) || (udp_len <= HDR_LEN) ||
                       (udp_len > bus.axis_i_length);

   assign in_fire          = bus.axis_i_tvalid && in_ready;
   assign bus.axis_i_tready = in_ready;

   assign bus.axis_o_length   = len_q;
   assign bus.axis_o_src_port = sport_q;
   assign bus.axis_o_dst_port = dport_q;
   assign bus.axis_o_src_ip   = sip_q;
   assign bus.axis_o_dst_ip   = dip_q;
   assign drop_count          = drop_q;

   // Byte enables for the closing payload beat: low rem bytes
   always_comb begin
      rem_keep = '0;
      for (int unsigned j = 0; j < AXIS_BYTES; j++) begin
         rem_keep[j] = (16'(j) < rem_q);
      end
   end

   // Input ready: header/discard never stall, except a new packet's first
   // header beat holds off until the output slot can take data
   always_comb begin
      in_ready = 1'b0;
      if (ready_en_q) begin
         unique case (state_q)
            HEADER:  in_ready = hdr_first ? pipe_ready : 1'b1;
            PAYLOAD: in_ready = pipe_ready;
            DISCARD: in_ready = 1'b1;
            default: in_ready = 1'b0;
         endcase
      end
   end

   // Next-state, header capture, payload byte accounting and drop decisions
   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      hdr_d      = hdr_q;
      ip_src_d   = ip_src_q;
      ip_dst_d   = ip_dst_q;
      rem_d      = rem_q;
      len_d      = len_q;
      sport_d    = sport_q;
      dport_d    = dport_q;
      sip_d      = sip_q;
      dip_d      = dip_q;
      drop_inc   = 1'b0;
      pipe_valid = 1'b0;
      pipe_keep  = '1;
      pipe_last  = 1'b0;

      unique case (state_q)
         HEADER: begin
            if (in_fire) begin
               hdr_d = hdr_full;
               if (hdr_first) begin
                  ip_src_d = bus.axis_i_src_ip;
                  ip_dst_d = bus.axis_i_dst_ip;
               end
               if (bus.axis_i_tlast) begin
                  // Packet ended inside the header: runt
                  drop_inc  = 1'b1;
                  hdr_cnt_d = 3'd0;
               end else if (!hdr_last) begin
                  hdr_cnt_d = hdr_cnt_q + 3'd1;
               end else begin
                  hdr_cnt_d = 3'd0;
                  if (hdr_bad) begin
                     drop_inc = 1'b1;
                     state_d  = DISCARD;
                  end else begin
                     rem_d   = udp_len - HDR_LEN;
                     len_d   = udp_len - HDR_LEN;
                     sport_d = hdr_u16(hdr_full, HDR_SRC_PORT_OFS);
                     dport_d = hdr_u16(hdr_full, HDR_DST_PORT_OFS);
                     sip_d   = cur_src_ip;
                     dip_d   = cur_dst_ip;
                     state_d = PAYLOAD;
                  end
               end
            end
         end
         PAYLOAD: begin
            if (in_fire) begin
               pipe_valid = 1'b1;
               if (rem_q <= BEAT_LEN) begin
                  // UDP payload ends here; any IP padding after it is trimmed
                  pipe_keep = rem_keep;
                  pipe_last = 1'b1;
                  rem_d     = '0;
                  state_d   = bus.axis_i_tlast ? HEADER : DISCARD;
               end else if (bus.axis_i_tlast) begin
                  // IP packet shorter than the UDP length claims: truncated
                  pipe_keep = bus.axis_i_tkeep;
                  pipe_last = 1'b1;
                  rem_d     = '0;
                  state_d   = HEADER;
               end else begin
                  rem_d = rem_q - BEAT_LEN;
               end
            end
         end
         DISCARD: begin
            if (in_fire && bus.axis_i_tlast) begin
               state_d = HEADER;
            end
         end
         default: state_d = HEADER;
      endcase
   end

   // Saturating drop counter
   always_comb begin
      drop_d = drop_q;
      if (drop_inc && (drop_q != 32'hFFFF_FFFF)) begin
         drop_d = drop_q + 32'd1;
      end
   end

   // State, header and sideband registers
   always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
         state_q    <= HEADER;
         ready_en_q <= 1'b0;
         hdr_cnt_q  <= 3'd0;
         hdr_q      <= '0;
         ip_src_q   <= '0;
         ip_dst_q   <= '0;
         rem_q      <= '0;
         drop_q     <= '0;
         len_q      <= '0;
         sport_q    <= '0;
         dport_q    <= '0;
         sip_q      <= '0;
         dip_q      <= '0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
         hdr_cnt_q  <= hdr_cnt_d;
         hdr_q      <= hdr_d;
         ip_src_q   <= ip_src_d;
         ip_dst_q   <= ip_dst_d;
         rem_q      <= rem_d;
         drop_q     <= drop_d;
         len_q      <= len_d;
         sport_q    <= sport_d;
         dport_q    <= dport_d;
         sip_q      <= sip_d;
         dip_q      <= dip_d;
      end
   end

   axis_pipeline_reg #(
      .DataBytes (AXIS_BYTES)
   ) u_out_reg (
      .clk_i     (clk),
      .rst_ni    (sresetn),
      .s_valid_i (pipe_valid),
      .s_ready_o (pipe_ready),
      .s_data_i  (bus.axis_i_tdata),
      .s_keep_i  (pipe_keep),
      .s_last_i  (pipe_last),
      .m_valid_o (bus.axis_o_tvalid),
      .m_ready_i (bus.axis_o_tready),
      .m_data_o  (bus.axis_o_tdata),
      .m_keep_o  (bus.axis_o_tkeep),
      .m_last_o  (bus.axis_o_tlast)
   );

endmodule

// File: tb/tb_udp_deframer.sv
// Scoreboard bench for udp_deframer with AXIS_BYTES=4: packets are driven from
// directed vectors, expected payload beats are queued, and a monitor checks
// every beat the deframer presents.
module tb_udp_deframer;

   localparam int unsigned B = 4;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [15:0] len;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [31:0] sip;
      logic [31:0] dip;
   } exp_t;

   logic        clk;
   logic        sresetn;
   logic [31:0] drop_count;
   int          vectors;
   int          miscompares;
   int          out_beats;
   int          pkt_id;
   int          bp_mode;
   int          base;
   exp_t        exp_q[$];
   exp_t        mon_e;

   udp_deframer_if #(.AXIS_BYTES(B)) bus ();

   udp_deframer #(
      .AXIS_BYTES (B)
   ) dut (
      .clk        (clk),
      .sresetn    (sresetn),
      .bus        (bus),
      .drop_count (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Downstream ready: 0 = always ready, 1 = random, 2 = held low
   initial begin
      bus.axis_o_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       bus.axis_o_tready = 1'b1;
            1:       bus.axis_o_tready = 1'($urandom_range(0, 1));
            default: bus.axis_o_tready = 1'b0;
         endcase
      end
   end

   // Monitor: a beat transfers at the next rising edge when valid and ready
   initial begin
      forever begin
         @(negedge clk);
         if (sresetn && bus.axis_o_tvalid && bus.axis_o_tready) begin
            out_beats++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected beat: got data 0x%0h, required no beat",
                        bus.axis_o_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat tdata", 64'(bus.axis_o_tdata), 64'(mon_e.data));
               chk("beat tkeep", 64'(bus.axis_o_tkeep), 64'(mon_e.keep));
               chk("beat tlast", 64'(bus.axis_o_tlast), 64'(mon_e.last));
               chk("sideband length", 64'(bus.axis_o_length), 64'(mon_e.len));
               chk("sideband src_port", 64'(bus.axis_o_src_port), 64'(mon_e.sport));
               chk("sideband dst_port", 64'(bus.axis_o_dst_port), 64'(mon_e.dport));
               chk("sideband src_ip", 64'(bus.axis_o_src_ip), 64'(mon_e.sip));
               chk("sideband dst_ip", 64'(bus.axis_o_dst_ip), 64'(mon_e.dip));
            end
         end
      end
   end

   // Present one input beat, starting just after a rising edge; returns just
   // after the edge that accepted it
   task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [7:0] proto, input logic [15:0] len_field,
                             input logic [31:0] sip, input logic [31:0] dip);
      bit done;
      bus.axis_i_tvalid   = 1'b1;
      bus.axis_i_tdata    = d;
      bus.axis_i_tkeep    = k;
      bus.axis_i_tlast    = l;
      bus.axis_i_protocol = proto;
      bus.axis_i_length   = len_field;
      bus.axis_i_src_ip   = sip;
      bus.axis_i_dst_ip   = dip;
      done = 1'b0;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk);
         done = bus.axis_i_tready;
         @(posedge clk);
         #1;
      end
      bus.axis_i_tvalid = 1'b0;
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL input beat timeout: got tready=0 for 1000 cycles, required 1");
      end
   endtask

   // Build an IP payload of ip_len bytes carrying a UDP header; when expect_out
   // is set, queue the payload beats the deframer must produce
   task automatic send_packet(input logic [7:0] proto, input logic [15:0] sport,
                              input logic [15:0] dport, input logic [15:0] udp_len,
                              input int ip_len, input logic [15:0] len_field,
                              input bit expect_out);
      logic [7:0]  pkt [64];
      logic [7:0]  hdr [8];
      logic [31:0] sip;
      logic [31:0] dip;
      logic [31:0] d;
      logic [3:0]  k;
      int          n_pay;
      int          nb;
      int          cnt;
      exp_t        e;
      pkt_id++;
      sip = 32'h0A00_0000 | 32'(pkt_id);
      dip = 32'hC0A8_0100 + 32'(pkt_id);
      hdr = '{sport[15:8], sport[7:0], dport[15:8], dport[7:0],
              udp_len[15:8], udp_len[7:0], 8'hBE, 8'hEF};
      for (int i = 0; i < 64; i++) begin
         pkt[i] = (i < ip_len) ? 8'(pkt_id * 16 + i * 3) : 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
         if (i < ip_len) pkt[i] = hdr[i];
      end
      if (expect_out) begin
         n_pay = int'(udp_len) - 8;
         if (ip_len - 8 < n_pay) n_pay = ip_len - 8;
         for (int o = 0; o < n_pay; o += 4) begin
            cnt     = n_pay - o;
            e.data  = {pkt[8+o+3], pkt[8+o+2], pkt[8+o+1], pkt[8+o]};
            e.keep  = (cnt >= 4) ? 4'hF : 4'((1 << cnt) - 1);
            e.last  = (o + 4 >= n_pay);
            e.len   = udp_len - 16'd8;
            e.sport = sport;
            e.dport = dport;
            e.sip   = sip;
            e.dip   = dip;
            exp_q.push_back(e);
         end
      end
      nb = (ip_len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         d = {pkt[4*b+3], pkt[4*b+2], pkt[4*b+1], pkt[4*b]};
         for (int j = 0; j < 4; j++) k[j] = (4 * b + j < ip_len);
         drive_beat(d, k, (b == nb - 1), proto, len_field, sip, dip);
      end
   endtask

   task automatic wait_idle(input string name);
      bit idle;
      idle = 1'b0;
      for (int t = 0; t < 3000 && !idle; t++) begin
         @(negedge clk);
         idle = (exp_q.size() == 0) && !bus.axis_o_tvalid;
      end
      if (!idle) begin
         vectors++;
         miscompares++;
         $display("FAIL %s drain: got %0d beats outstanding, required 0", name, exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      out_beats   = 0;
      pkt_id      = 0;
      bp_mode     = 0;
      sresetn     = 1'b0;
      bus.axis_i_tvalid   = 1'b0;
      bus.axis_i_tlast    = 1'b0;
      bus.axis_i_tdata    = '0;
      bus.axis_i_tkeep    = '0;
      bus.axis_i_length   = '0;
      bus.axis_i_protocol = '0;
      bus.axis_i_src_ip   = '0;
      bus.axis_i_dst_ip   = '0;

      // Reset values and first tready edge
      repeat (3) @(posedge clk);
      #2;
      chk("reset tready", 64'(bus.axis_i_tready), 64'd0);
      chk("reset o_tvalid", 64'(bus.axis_o_tvalid), 64'd0);
      chk("reset drop_count", 64'(drop_count), 64'd0);
      @(negedge clk);
      sresetn = 1'b1;
      #1;
      chk("tready before first edge", 64'(bus.axis_i_tready), 64'd0);
      @(posedge clk);
      #1;
      chk("tready after first edge", 64'(bus.axis_i_tready), 64'd1);

      // Nominal: UDP length 20, 12 payload bytes -> 3 full beats
      base = out_beats;
      send_packet(8'd17, 16'h1234, 16'h0050, 16'd20, 20, 16'd20, 1'b1);
      wait_idle("nominal");
      chk("nominal beat count", 64'(out_beats - base), 64'd3);
      chk("nominal drop_count", 64'(drop_count), 64'd0);

      // Padding trim: IP 24 bytes, UDP length 13 -> keep 0xF then 0x1
      base = out_beats;
      send_packet(8'd17, 16'h0400, 16'h0401, 16'd13, 24, 16'd24, 1'b1);
      wait_idle("padding");
      chk("padding beat count", 64'(out_beats - base), 64'd2);
      chk("padding drop_count", 64'(drop_count), 64'd0);

      // Non-UDP discarded, following UDP packet unaffected
      send_packet(8'd6, 16'h0001, 16'h0002, 16'd40, 40, 16'd40, 1'b0);
      base = out_beats;
      send_packet(8'd17, 16'hABCD, 16'h0035, 16'd16, 16, 16'd16, 1'b1);
      wait_idle("non-udp");
      chk("after non-udp beat count", 64'(out_beats - base), 64'd2);
      chk("non-udp drop_count", 64'(drop_count), 64'd1);

      // Runt (tlast on first header beat), then UDP length 4
      send_packet(8'd17, 16'h1111, 16'h2222, 16'd20, 4, 16'd4, 1'b0);
      send_packet(8'd17, 16'h1111, 16'h2222, 16'd4, 16, 16'd16, 1'b0);
      wait_idle("runt");
      chk("runt/len4 drop_count", 64'(drop_count), 64'd3);

      // Length boundaries: 8 (empty), > IP length, tlast on final header beat
      send_packet(8'd17, 16'h3333, 16'h4444, 16'd8, 16, 16'd16, 1'b0);
      send_packet(8'd17, 16'h3333, 16'h4444, 16'd40, 20, 16'd20, 1'b0);
      send_packet(8'd17, 16'h3333, 16'h4444, 16'd20, 8, 16'd8, 1'b0);
      base = out_beats;
      send_packet(8'd17, 16'h5555, 16'h6666, 16'd9, 12, 16'd12, 1'b1);
      wait_idle("length bounds");
      chk("one-byte payload beat count", 64'(out_beats - base), 64'd1);
      chk("length bounds drop_count", 64'(drop_count), 64'd6);

      // Truncated: IP length field 24 but tlast after 14 bytes -> keep 0xF, 0x3
      base = out_beats;
      send_packet(8'd17, 16'h7777, 16'h8888, 16'd24, 14, 16'd24, 1'b1);
      wait_idle("truncated");
      chk("truncated beat count", 64'(out_beats - base), 64'd2);
      chk("truncated drop_count", 64'(drop_count), 64'd6);

      // Random backpressure across back-to-back packets
      bp_mode = 1;
      send_packet(8'd17, 16'h1234, 16'h0050, 16'd20, 20, 16'd20, 1'b1);
      send_packet(8'd17, 16'h0400, 16'h0401, 16'd13, 24, 16'd24, 1'b1);
      send_packet(8'd6, 16'h0001, 16'h0002, 16'd20, 20, 16'd20, 1'b0);
      send_packet(8'd17, 16'h9000, 16'h9001, 16'd30, 30, 16'd30, 1'b1);
      send_packet(8'd17, 16'h5555, 16'h6666, 16'd9, 12, 16'd12, 1'b1);
      send_packet(8'd17, 16'hCAFE, 16'hF00D, 16'd20, 20, 16'd20, 1'b1);
      wait_idle("backpressure");
      chk("backpressure drop_count", 64'(drop_count), 64'd7);
      bp_mode = 0;

      // Reset mid-payload with an output beat held
      bp_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      drive_beat(32'h5000_3412, 4'hF, 1'b0, 8'd17, 16'd20, 32'h0A00_0063, 32'h0A00_0064);
      drive_beat(32'hEFBE_1400, 4'hF, 1'b0, 8'd17, 16'd20, 32'h0A00_0063, 32'h0A00_0064);
      drive_beat(32'hDEAD_BEEF, 4'hF, 1'b0, 8'd17, 16'd20, 32'h0A00_0063, 32'h0A00_0064);
      chk("held beat tvalid", 64'(bus.axis_o_tvalid), 64'd1);
      chk("held beat tdata", 64'(bus.axis_o_tdata), 64'hDEAD_BEEF);
      chk("held beat length", 64'(bus.axis_o_length), 64'd12);
      chk("held beat src_ip", 64'(bus.axis_o_src_ip), 64'h0A00_0063);
      #2;
      sresetn = 1'b0;
      #1;
      chk("mid reset o_tvalid", 64'(bus.axis_o_tvalid), 64'd0);
      chk("mid reset o_tdata", 64'(bus.axis_o_tdata), 64'd0);
      chk("mid reset o_tkeep", 64'(bus.axis_o_tkeep), 64'd0);
      chk("mid reset o_length", 64'(bus.axis_o_length), 64'd0);
      chk("mid reset src_port", 64'(bus.axis_o_src_port), 64'd0);
      chk("mid reset dst_ip", 64'(bus.axis_o_dst_ip), 64'd0);
      chk("mid reset drop_count", 64'(drop_count), 64'd0);
      chk("mid reset tready", 64'(bus.axis_i_tready), 64'd0);
      bp_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sresetn = 1'b1;
      @(posedge clk);
      #1;
      base = out_beats;
      send_packet(8'd17, 16'h1234, 16'h0050, 16'd20, 20, 16'd20, 1'b1);
      wait_idle("post reset");
      chk("post reset beat count", 64'(out_beats - base), 64'd3);
      chk("post reset drop_count", 64'(drop_count), 64'd0);

      chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/udp_deframer.md
# udp_deframer

Strips the 8-byte UDP header from the IP payload stream produced by the IP deframer and emits the UDP payload as AXI-Stream with ports, IP addresses and payload length as per-packet sideband. Non-UDP and malformed packets are consumed and discarded. It sits directly downstream of the IP deframer and feeds the application/socket layer. The UDP checksum is not checked.

## Interface
- AXIS_BYTES, 4, bytes per beat; legal values 1, 2, 4, 8 (divides the header, so payload stays beat-aligned)
- clk  input  1  clock
- sresetn  input  1  asynchronous active-low reset
- axis_i_tready / tvalid / tlast  out/in/in  1  IP payload stream handshake
- axis_i_tdata  input  8*AXIS_BYTES  first stream byte in [7:0]
- axis_i_tkeep  input  AXIS_BYTES  all-ones except possibly the tlast beat
- axis_i_length  input  16  IP payload length in bytes; valid on the first beat, stable to tlast
- axis_i_protocol  input  8  IP protocol; valid on the first beat, stable to tlast
- axis_i_src_ip, axis_i_dst_ip  input  32 each  valid on the first beat, stable to tlast
- axis_o_tready / tvalid / tlast  in/out/out  1  UDP payload stream handshake
- axis_o_tdata  output  8*AXIS_BYTES  payload data
- axis_o_tkeep  output  AXIS_BYTES  payload byte enables
- axis_o_length  output  16  UDP payload bytes = UDP length − 8
- axis_o_src_port, axis_o_dst_port  output  16 each  UDP ports
- axis_o_src_ip, axis_o_dst_ip  output  32 each  latched from input
- drop_count  output  32  saturating count of discarded packets

## Operation
- States: HEADER, PAYLOAD, DISCARD. Reset enters HEADER.
- HEADER
  - Accepts 8/AXIS_BYTES beats; tready=1.
  - Captures the big-endian header: byte 0..1 src port, 2..3 dst port, 4..5 length, 6..7 checksum (ignored).
  - Also latches src_ip/dst_ip from the first beat.
- On the final header beat:
  - If the header beat carries tlast, drop_count++ and stay in HEADER (discard).
  - Otherwise, if protocol≠17, UDP length≤8, or UDP length>axis_i_length: drop_count++ and go to DISCARD.
  - Otherwise: load rem = UDP length − 8, drive sideband outputs, go to PAYLOAD.
- Runt packet: tlast on any non-final header beat → drop_count++, stay in HEADER.
- PAYLOAD: each accepted input beat is forwarded.
  - If rem ≤ AXIS_BYTES: tkeep = low rem bytes set, tlast=1. Next state is HEADER if input tlast is on this beat, else DISCARD (trailing padding trimmed).
  - Else if input tlast: forward as-is with tlast=1 (truncated packet) and go to HEADER.
  - Else: forward tkeep all-ones and set rem −= AXIS_BYTES.
- DISCARD: tready=1, outputs nothing, returns to HEADER after the tlast beat is accepted.
- drop_count saturates at 0xFFFFFFFF.
- Trimmed and truncated packets are not counted as drops.

## Timing
- Reset (asynchronous, immediate):
  - axis_i_tready=0, axis_o_tvalid=0, and all data/sideband outputs, drop_count and rem = 0.
  - tready rises on the first clk edge after deassertion.
- Output is a single register stage: a payload beat accepted at edge N is presented at N+1.
- No bubbles: in PAYLOAD, axis_i_tready = !axis_o_tvalid || axis_o_tready.
- In HEADER and DISCARD, tready=1, so header and discard beats never stall, except that the first header beat waits until the pending output beat drains.
- axis_o_tvalid, once high, holds with data stable until tready (AXIS rule).
- Sideband outputs update only on the final header beat of an accepted packet and stay stable until the next accepted packet's header completes.
- Back-to-back packets: a new header can be accepted on the cycle after the previous tlast.
- Reset mid-packet: the output beat is lost and the remainder of the input packet is treated as a fresh HEADER start. Upstream is also reset, so this is acceptable.

## Structure
- Package udp_pkg:
  - UDP_HEADER_BYTES=8
  - IP_PROTO_UDP=8'd17
  - udp_state_t enum {HEADER, PAYLOAD, DISCARD}
  - header field byte offsets
- Sub-module axis_pipeline_reg: a one-deep AXIS output register with tdata/tkeep/tlast, reused by other deframers.
- Header capture and byte-count logic live in the top module.

## Test plan
- Nominal UDP packet, AXIS_BYTES=4:
  - Stimulus: protocol 17, src port 0x1234, dst port 0x0050, UDP length 20, 12 payload bytes.
  - Response: 3 output beats, tkeep 0xF,0xF,0xF, tlast on beat 3, axis_o_length=12, ports correct.
- Padding trim:
  - Stimulus: IP payload 24 bytes, UDP length 13.
  - Response: 2 output beats, second with tkeep=0x1 and tlast; remaining input consumed; drop_count unchanged.
- Non-UDP packet:
  - Stimulus: protocol 6, 40 bytes.
  - Response: no output, drop_count=1, next UDP packet passes unaffected.
- Runt and invalid length:
  - Stimulus: 1-beat packet with tlast, then a packet with UDP length=4.
  - Response: no output, drop_count=2.
- Backpressure:
  - Stimulus: axis_o_tready toggled randomly across back-to-back packets.
  - Response: byte-exact payload, no duplicate or lost beats, sideband stable per packet.
- Reset:
  - Stimulus: sresetn low mid-payload.
  - Response: outputs 0 immediately; a clean packet afterwards is deframed correctly.
